// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the registered ripple full subtractor.
// fs_cell_ref is the golden 1-bit cell, kept here so benches can reuse it.
package full_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Returns {bout, diff} for a single subtractor cell.
    function automatic logic [1:0] fs_cell_ref(input logic a, input logic b, input logic bin);
        logic d;
        logic bo;
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~(a ^ b) & bin);
        return {bo, d};
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full-subtractor cell: diff = a ^ b ^ bin, with borrow-out.
module full_subtractor_cell
    import full_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit full subtractor built from a ripple chain of 1-bit cells.
// Define FULL_SUBTRACTOR_OVF_EN to add a registered signed-overflow output (ovf).
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FULL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] d_chain;

    assign br[0] = bin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_subtractor_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .bin  (br[gi]),
                .diff (d_chain[gi]),
                .bout (br[gi+1])
            );
        end
    endgenerate

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    // Results only load on accepted cycles; otherwise the last result is held.
    always_comb begin
        out_valid_d = in_valid;
        diff_d      = diff_q;
        bout_d      = bout_q;
        if (in_valid) begin
            diff_d = d_chain;
            bout_d = br[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef FULL_SUBTRACTOR_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: borrow into the sign bit differs from borrow out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = br[WIDTH] ^ br[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against an arithmetic model,
// plus directed vectors with hand-computed results.
module tb_full_subtractor;
    import full_subtractor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic       ov1, d1, bo1;
    logic       v8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ov8, bo8;
    logic [7:0] d8;
    logic       ovf1, ovf8;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(d1), .bout(bo1)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(ovf1)
`endif
    );

    full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(d8), .bout(bo8)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(ovf8)
`endif
    );

`ifndef FULL_SUBTRACTOR_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the values seen at each edge.
    logic       m1_v, m1_d, m1_bo, m1_ovf;
    logic       m8_v, m8_bo, m8_ovf;
    logic [7:0] m8_d;

    always @(posedge clk) begin
        int r, sr;
        if (rst) begin
            m1_v <= 1'b0; m1_d <= 1'b0; m1_bo <= 1'b0; m1_ovf <= 1'b0;
            m8_v <= 1'b0; m8_d <= '0;   m8_bo <= 1'b0; m8_ovf <= 1'b0;
        end else begin
            m1_v <= v1;
            if (v1) begin
                r  = int'(a1) - int'(b1) - int'(bin1);
                sr = -int'(a1) + int'(b1) - int'(bin1);   // 1-bit signed: 1 means -1
                m1_d   <= r[0];
                m1_bo  <= (r < 0);
                m1_ovf <= (sr > 0) || (sr < -1);
            end
            m8_v <= v8;
            if (v8) begin
                r  = int'(a8) - int'(b8) - int'(bin8);
                sr = int'($signed(a8)) - int'($signed(b8)) - int'(bin8);
                m8_d   <= r[7:0];
                m8_bo  <= (r < 0);
                m8_ovf <= (sr > 127) || (sr < -128);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("w1_valid", 32'(ov1), 32'(m1_v));
            chk("w1_diff",  32'(d1),  32'(m1_d));
            chk("w1_bout",  32'(bo1), 32'(m1_bo));
            chk("w8_valid", 32'(ov8), 32'(m8_v));
            chk("w8_diff",  32'(d8),  32'(m8_d));
            chk("w8_bout",  32'(bo8), 32'(m8_bo));
`ifdef FULL_SUBTRACTOR_OVF_EN
            chk("w1_ovf",   32'(ovf1), 32'(m1_ovf));
            chk("w8_ovf",   32'(ovf8), 32'(m8_ovf));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] v;
        logic [1:0] ref2;
        logic       dtab [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       btab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Pin the package golden cell against the hand table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            ref2 = fs_cell_ref(v[2], v[1], v[0]);
            chk($sformatf("ref_diff_%0d", i), 32'(ref2[0]), 32'(dtab[i]));
            chk($sformatf("ref_bout_%0d", i), 32'(ref2[1]), 32'(btab[i]));
        end

        repeat (2) step();
        chk("rst_w1_valid", 32'(ov1), 32'd0);
        chk("rst_w1_diff",  32'(d1),  32'd0);
        chk("rst_w8_valid", 32'(ov8), 32'd0);
        chk("rst_w8_diff",  32'(d8),  32'd0);
        chk("rst_w8_bout",  32'(bo8), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // WIDTH=1 exhaustive, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = 3'(i);
            v1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
            step();
            $display("[TB] w1 a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d valid=%0d",
                     a1, b1, bin1, d1, bo1, ov1);
            chk($sformatf("w1_vec%0d_valid", i), 32'(ov1), 32'd1);
            chk($sformatf("w1_vec%0d_diff", i),  32'(d1),  32'(dtab[i]));
            chk($sformatf("w1_vec%0d_bout", i),  32'(bo1), 32'(btab[i]));
        end

        // Reset overrides a valid input in the same cycle.
        @(negedge clk);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0; rst = 1'b1;
        step();
        $display("[TB] reset with valid 1-0-0 -> diff=%0d bout=%0d valid=%0d", d1, bo1, ov1);
        chk("rstv_valid", 32'(ov1), 32'd0);
        chk("rstv_diff",  32'(d1),  32'd0);
        chk("rstv_bout",  32'(bo1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hold: result stays while in_valid is low and inputs wander.
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; bin1 = 1'b1;
        step();
        chk("hold_load_diff", 32'(d1),  32'd1);
        chk("hold_load_bout", 32'(bo1), 32'd1);
        @(negedge clk);
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
        step();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b1;
        step();
        $display("[TB] hold -> diff=%0d bout=%0d valid=%0d", d1, bo1, ov1);
        chk("hold_valid", 32'(ov1), 32'd0);
        chk("hold_diff",  32'(d1),  32'd1);
        chk("hold_bout",  32'(bo1), 32'd1);

        // WIDTH=8 directed boundaries.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
        step();
        $display("[TB] w8 00-FF-1 -> diff=%0h bout=%0d", d8, bo8);
        chk("w8_wrap_diff", 32'(d8),  32'h00);
        chk("w8_wrap_bout", 32'(bo8), 32'd1);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        step();
        $display("[TB] w8 80-01-0 -> diff=%0h bout=%0d ovf=%0d", d8, bo8, ovf8);
        chk("w8_80_diff", 32'(d8),  32'h7F);
        chk("w8_80_bout", 32'(bo8), 32'd0);
`ifdef FULL_SUBTRACTOR_OVF_EN
        chk("w8_80_ovf",  32'(ovf8), 32'd1);
`endif
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        step();
        $display("[TB] w8 05-03-0 -> diff=%0h bout=%0d ovf=%0d", d8, bo8, ovf8);
        chk("w8_05_diff", 32'(d8),  32'h02);
        chk("w8_05_bout", 32'(bo8), 32'd0);
`ifdef FULL_SUBTRACTOR_OVF_EN
        chk("w8_05_ovf",  32'(ovf8), 32'd0);
`endif
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h5A; bin8 = 1'b0;
        step();
        chk("w8_eq_diff", 32'(d8),  32'h00);
        chk("w8_eq_bout", 32'(bo8), 32'd0);

        // Random WIDTH=8 traffic; the model compare checks every cycle.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            v8   = ($urandom_range(0, 3) != 0);
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            bin8 = 1'($urandom_range(0, 1));
            if (i % 100 == 0)
                $display("[TB] w8 rnd %0d a=%0h b=%0h bin=%0d valid=%0d", i, a8, b8, bin8, v8);
        end
        @(negedge clk);
        v8 = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
